// File: rtl/rf_ctrl_pkg.sv
// rf_ctrl_pkg
// Shared constants and types for the register-file write sequencer.
// There are no ports. The package provides the well-known register indices,
// the default stack pointer value, the 5-bit register index type and the
// sequencer state encoding.
package rf_ctrl_pkg;

    typedef logic [4:0] reg_idx_t;

    typedef enum logic {
        S_INIT,
        S_RUN
    } state_t;

    localparam reg_idx_t    REG_ZERO        = 5'd0;
    localparam reg_idx_t    REG_SP          = 5'd29;
    localparam reg_idx_t    REG_EPC         = 5'd26;
    localparam reg_idx_t    REG_LAST        = 5'd31;
    localparam logic [31:0] SP_INIT_DEFAULT = 32'h0000fffc;

endpackage

// File: rtl/rf_wr_arb.sv
// rf_wr_arb
// Grant logic for the two write requesters. req0 (core writeback) normally
// wins. req1 (exception/debug) is protected by a starvation counter: once it
// has stalled STARVE_LIMIT consecutive edges, it takes priority over req0.
// Ports:
//   clk, reset          - clock and synchronous active-high reset
//   en                  - sequencer is in its run phase
//   req0_valid          - core writeback request pending
//   req1_valid          - exception/debug request pending
//   gnt0, gnt1          - combinational grants (at most one high)
module rf_wr_arb
#(
    parameter int unsigned STARVE_LIMIT = 4
)
(
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic req0_valid,
    input  logic req1_valid,
    output logic gnt0,
    output logic gnt1
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] starve_cnt;

    // Grants depend only on valids, the counter and the phase, never on data.
    // Reset forces both grants low so that nothing is accepted while it is high.
    always_comb begin
        gnt1 = 1'b0;
        gnt0 = 1'b0;
        if (en && !reset) begin
            gnt1 = req1_valid && (!req0_valid || starve_cnt == LIMIT);
            gnt0 = req0_valid && !gnt1;
        end
    end

    // Counts consecutive stalled req1 edges and saturates at the limit.
    // A req1 transfer or a dropped req1_valid clears it.
    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt <= 4'd0;
        end else if (req1_valid && !gnt1) begin
            if (starve_cnt != LIMIT) begin
                starve_cnt <= starve_cnt + 4'd1;
            end
        end else begin
            starve_cnt <= 4'd0;
        end
    end

endmodule

// File: rtl/rf_write_sequencer.sv
// rf_write_sequencer
// Owns the single write port of the 32x32 register file. After reset it walks
// registers 1..31 and writes their initial values (0, or SP_INIT for SP_REG).
// It then arbitrates the port between the core writeback path (req0) and the
// exception/debug path (req1).
// Ports:
//   clk, reset                    - clock and synchronous active-high reset
//   init_done                     - init walk has completed
//   req0_valid/ready/addr/data    - core writeback handshake
//   req1_valid/ready/addr/data    - exception/debug handshake
//   rf_RegWrite                   - registered write enable
//   rf_Write_register             - registered write address
//   rf_Write_data                 - registered write data
//   last_grant                    - requester of the most recent accepted write
module rf_write_sequencer
    import rf_ctrl_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter reg_idx_t    SP_REG       = REG_SP,
    parameter logic [31:0] SP_INIT      = SP_INIT_DEFAULT
)
(
    input  logic        clk,
    input  logic        reset,
    output logic        init_done,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [4:0]  req0_addr,
    input  logic [31:0] req0_data,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [4:0]  req1_addr,
    input  logic [31:0] req1_data,
    output logic        rf_RegWrite,
    output logic [4:0]  rf_Write_register,
    output logic [31:0] rf_Write_data,
    output logic        last_grant
);

    state_t   state;
    reg_idx_t idx;

    rf_wr_arb #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_arb (
        .clk        (clk),
        .reset      (reset),
        .en         (state == S_RUN),
        .req0_valid (req0_valid),
        .req1_valid (req1_valid),
        .gnt0       (req0_ready),
        .gnt1       (req1_ready)
    );

    // Main sequencer: the init walk, then one registered write per accepted
    // request. A write to register 0 is accepted but emits all-zero outputs.
    // Idle cycles also drive the address to 0, because the register file
    // forwards Write_data to any read whose address matches Write_register,
    // even when RegWrite is low.
    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= S_INIT;
            idx               <= 5'd1;
            init_done         <= 1'b0;
            last_grant        <= 1'b0;
            rf_RegWrite       <= 1'b0;
            rf_Write_register <= REG_ZERO;
            rf_Write_data     <= 32'd0;
        end else begin
            case (state)
                S_INIT: begin
                    rf_RegWrite       <= 1'b1;
                    rf_Write_register <= idx;
                    rf_Write_data     <= (idx == SP_REG) ? SP_INIT : 32'd0;
                    if (idx == REG_LAST) begin
                        state     <= S_RUN;
                        init_done <= 1'b1;
                    end else begin
                        idx <= idx + 5'd1;
                    end
                end
                S_RUN: begin
                    if (req1_ready) begin
                        rf_RegWrite       <= (req1_addr != REG_ZERO);
                        rf_Write_register <= req1_addr;
                        rf_Write_data     <= (req1_addr != REG_ZERO) ? req1_data : 32'd0;
                        last_grant        <= 1'b1;
                    end else if (req0_ready) begin
                        rf_RegWrite       <= (req0_addr != REG_ZERO);
                        rf_Write_register <= req0_addr;
                        rf_Write_data     <= (req0_addr != REG_ZERO) ? req0_data : 32'd0;
                        last_grant        <= 1'b0;
                    end else begin
                        rf_RegWrite       <= 1'b0;
                        rf_Write_register <= REG_ZERO;
                        rf_Write_data     <= 32'd0;
                    end
                end
                default: begin
                    state <= S_INIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rf_write_sequencer.sv
// tb_rf_write_sequencer
// Self-checking bench for rf_write_sequencer. A behavioural model tracks the
// expected port behaviour from the rules of the write port: the init walk,
// priority with starvation override, register-0 suppression and idle zeroing.
module tb_rf_write_sequencer;

    localparam int          STARVE_LIMIT = 4;
    localparam int          SP_REG       = 29;
    localparam logic [31:0] SP_INIT      = 32'h0000fffc;

    logic        clk = 1'b0;
    logic        reset;
    logic        init_done;
    logic        req0_valid, req0_ready;
    logic [4:0]  req0_addr;
    logic [31:0] req0_data;
    logic        req1_valid, req1_ready;
    logic [4:0]  req1_addr;
    logic [31:0] req1_data;
    logic        rf_RegWrite;
    logic [4:0]  rf_Write_register;
    logic [31:0] rf_Write_data;
    logic        last_grant;

    always #5 clk = ~clk;

    rf_write_sequencer #(
        .STARVE_LIMIT (STARVE_LIMIT),
        .SP_REG       (5'(SP_REG)),
        .SP_INIT      (SP_INIT)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .init_done         (init_done),
        .req0_valid        (req0_valid),
        .req0_ready        (req0_ready),
        .req0_addr         (req0_addr),
        .req0_data         (req0_data),
        .req1_valid        (req1_valid),
        .req1_ready        (req1_ready),
        .req1_addr         (req1_addr),
        .req1_data         (req1_data),
        .rf_RegWrite       (rf_RegWrite),
        .rf_Write_register (rf_Write_register),
        .rf_Write_data     (rf_Write_data),
        .last_grant        (last_grant)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: how far the init walk has got, how many edges
    // req1 has waited in a row, and the outputs the port should present.
    bit          m_running;
    int          m_walk;
    int          m_waited;
    bit          m_we;
    int          m_reg;
    logic [31:0] m_data;
    bit          m_done;
    bit          m_last;

    logic obs_r0, obs_r1;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive the inputs, check the readies, let the edge happen,
    // advance the model and check the registered outputs.
    task automatic applyStimulus(input logic rst,
                                 input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                                 input logic v1, input logic [4:0] a1, input logic [31:0] d1);
        bit e_r0, e_r1;
        @(negedge clk);
        reset = rst;
        req0_valid = v0; req0_addr = a0; req0_data = d0;
        req1_valid = v1; req1_addr = a1; req1_data = d1;
        #1;
        e_r0 = 0; e_r1 = 0;
        if (!rst && m_running) begin
            e_r1 = v1 && (!v0 || m_waited >= STARVE_LIMIT);
            e_r0 = v0 && !e_r1;
        end
        checkOutput("req0_ready", {31'd0, req0_ready}, {31'd0, e_r0});
        checkOutput("req1_ready", {31'd0, req1_ready}, {31'd0, e_r1});
        obs_r0 = req0_ready;
        obs_r1 = req1_ready;
        @(posedge clk);
        if (rst) begin
            m_running = 0; m_walk = 1; m_waited = 0;
            m_we = 0; m_reg = 0; m_data = 0; m_done = 0; m_last = 0;
        end else if (!m_running) begin
            m_we = 1; m_reg = m_walk;
            m_data = (m_walk == SP_REG) ? SP_INIT : 32'd0;
            if (m_walk == 31) begin
                m_running = 1; m_done = 1;
            end else begin
                m_walk++;
            end
            m_waited = (v1 && !e_r1) ? ((m_waited < STARVE_LIMIT) ? m_waited + 1 : m_waited) : 0;
        end else begin
            if (e_r1 || e_r0) begin
                m_reg  = e_r1 ? int'(a1) : int'(a0);
                m_data = e_r1 ? d1 : d0;
                m_we   = (m_reg != 0);
                if (!m_we) m_data = 0;
                m_last = e_r1;
            end else begin
                m_we = 0; m_reg = 0; m_data = 0;
            end
            m_waited = (v1 && !e_r1) ? ((m_waited < STARVE_LIMIT) ? m_waited + 1 : m_waited) : 0;
        end
        #1;
        checkOutput("rf_RegWrite", {31'd0, rf_RegWrite}, {31'd0, m_we});
        checkOutput("rf_Write_register", {27'd0, rf_Write_register}, 32'(m_reg));
        checkOutput("rf_Write_data", rf_Write_data, m_data);
        checkOutput("init_done", {31'd0, init_done}, {31'd0, m_done});
        checkOutput("last_grant", {31'd0, last_grant}, {31'd0, m_last});
    endtask

    task automatic idleCycles(input logic rst, input int n);
        for (int i = 0; i < n; i++) applyStimulus(rst, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
    endtask

    // Holds req0 continuously with req1 pending and measures how many cycles
    // req1 waits before it is granted.
    task automatic starveCheck(input string tag);
        int  stalls;
        bit  granted;
        stalls = 0; granted = 0;
        for (int i = 0; i < 12 && !granted; i++) begin
            applyStimulus(0, 1, 5'd8, 32'h11110000 + 32'(i), 1, 5'd26, 32'h00400010);
            if (obs_r1) granted = 1;
            else stalls++;
        end
        checkOutput({tag, "_granted"}, {31'd0, granted}, 32'd1);
        checkOutput({tag, "_stalls"}, 32'(stalls), 32'(STARVE_LIMIT));
        checkOutput({tag, "_last_grant"}, {31'd0, last_grant}, 32'd1);
        applyStimulus(0, 1, 5'd8, 32'h22220000, 0, 5'd0, 32'd0);
        checkOutput({tag, "_req0_resumes"}, {31'd0, obs_r0}, 32'd1);
    endtask

    initial begin
        bit          p0, p1;
        logic [4:0]  qa0, qa1;
        logic [31:0] qd0, qd1;

        reset = 1'b1;
        req0_valid = 0; req0_addr = 0; req0_data = 0;
        req1_valid = 0; req1_addr = 0; req1_data = 0;
        m_running = 0; m_walk = 1; m_waited = 0;
        m_we = 0; m_reg = 0; m_data = 0; m_done = 0; m_last = 0;
        $display("[TB] start");

        // Reset, then the full init walk with no requests.
        idleCycles(1, 3);
        idleCycles(0, 31);
        checkOutput("init_done_after_E31", {31'd0, init_done}, 32'd1);

        // Single req0 write, then idle.
        applyStimulus(0, 1, 5'd8, 32'hdeadbeef, 0, 5'd0, 32'd0);
        idleCycles(0, 2);

        // Starvation guard.
        starveCheck("starve1");
        idleCycles(0, 1);

        // Write to register 0 is accepted but suppressed.
        applyStimulus(0, 1, 5'd0, 32'h12345678, 0, 5'd0, 32'd0);
        checkOutput("reg0_accepted", {31'd0, obs_r0}, 32'd1);
        idleCycles(0, 1);

        // Randomised traffic with held requests.
        p0 = 0; p1 = 0; qa0 = 0; qa1 = 0; qd0 = 0; qd1 = 0;
        for (int i = 0; i < 300; i++) begin
            if (!p0 && $urandom_range(0, 9) < 7) begin
                p0 = 1; qa0 = 5'($urandom); qd0 = $urandom;
            end
            if (!p1 && $urandom_range(0, 9) < 4) begin
                p1 = 1; qa1 = 5'($urandom); qd1 = $urandom;
            end
            applyStimulus(0, p0, qa0, qd0, p1, qa1, qd1);
            if (obs_r0) p0 = 0;
            if (obs_r1) p1 = 0;
        end
        idleCycles(0, 1);

        // Reset in the middle of the init walk (idx 15), then a full walk.
        idleCycles(1, 2);
        idleCycles(0, 14);
        idleCycles(1, 1);
        checkOutput("midinit_reset_done", {31'd0, init_done}, 32'd0);
        idleCycles(0, 31);

        // Reset while req1 has stalled three cycles.
        for (int i = 0; i < 3; i++)
            applyStimulus(0, 1, 5'd3, 32'h33330000 + 32'(i), 1, 5'd26, 32'h00400010);
        checkOutput("stalled_before_reset", {31'd0, obs_r1}, 32'd0);
        idleCycles(1, 2);
        idleCycles(0, 31);
        starveCheck("starve2");
        idleCycles(0, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rf_write_sequencer.md
Name: rf_write_sequencer

Overview:
- Owns the single write port of the 32x32 register file in the multi-cycle CPU.
- After reset, walks registers 1..31 and writes their initial values: 0, except $sp, which gets SP_INIT.
- Afterwards arbitrates the write port between the core writeback path (req0) and the exception/debug path (req1, e.g. EPC into $26).
- Uses valid/ready handshakes and a starvation guard so req1 cannot be locked out.

Parameters:
- STARVE_LIMIT, 4, consecutive stalled req1 cycles after which req1 overrides req0 priority; legal range 1..15.
- SP_REG, 29, register index that receives SP_INIT during the init walk.
- SP_INIT, 32'h0000fffc, initial stack pointer value.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- init_done  out  1  high once the init walk has completed.
- req0_valid  in  1  core writeback request.
- req0_ready  out  1  req0 accepted this cycle.
- req0_addr  in  5  destination register.
- req0_data  in  32  write value.
- req1_valid  in  1  exception/debug write request.
- req1_ready  out  1  req1 accepted this cycle.
- req1_addr  in  5  destination register.
- req1_data  in  32  write value.
- rf_RegWrite  out  1  register file write enable.
- rf_Write_register  out  5  register file write address.
- rf_Write_data  out  32  register file write data.
- last_grant  out  1  requester of the most recent accepted write (0/1).

Behaviour:
- One clock domain. Reset is synchronous and active-high on clk.
- All rf_* outputs are registered.
- Reset values: rf_RegWrite=0, rf_Write_register=0, rf_Write_data=0, init_done=0, last_grant=0, state=S_INIT, idx=1, starve_cnt=0. req0_ready and req1_ready are 0 while reset is high.
- Edge numbering: E1 is the first rising edge with reset low.

S_INIT:
- After edge Ek (k=1..31), rf_* = {1, k, (k==SP_REG)?SP_INIT:0}.
- At E31 the state moves to S_RUN and init_done=1.
- Both ready signals are 0 throughout S_INIT.

S_RUN handshake:
- A transfer occurs when valid&&ready are both high at a rising edge.
- The requester holds addr/data stable while valid=1 and ready=0.
- Readies are combinational from valids, starve_cnt and state. They never depend on data.
- At most one ready is high per cycle.

Arbitration:
- Default: req0 has priority.
- req1 is granted when req1_valid && (!req0_valid || starve_cnt==STARVE_LIMIT).

Starvation counter:
- Increments on each edge where req1_valid && !req1_ready.
- Saturates at STARVE_LIMIT.
- Clears on a req1 transfer, and on any edge where req1_valid=0.

Latency: a transfer at edge En drives rf_* = {addr!=0, addr, data} after En. The register file commits the write at E(n+1).

Register 0:
- A transfer with addr==0 is accepted (ready behaves normally).
- It produces rf_RegWrite=0, rf_Write_register=0, rf_Write_data=0.

Idle:
- Any edge in S_RUN without a transfer loads rf_* = {0, 0, 0}.
- rf_Write_register is forced to 0 when idle because the register file bypasses Write_data to any read whose address matches Write_register, regardless of RegWrite.

Other rules:
- last_grant updates only on a transfer.
- Simultaneous valids below the limit: req0 wins and req1 stalls.
- Reset asserted in any state, including mid-init or mid-handshake, returns to the reset values. Pending requests are dropped and the requester must re-present them. The init walk restarts from 1.

Decomposition:
- Package rf_ctrl_pkg holds:
  - constants REG_ZERO=5'd0, REG_SP=5'd29, REG_EPC=5'd26, SP_INIT_DEFAULT=32'h0000fffc;
  - state enum {S_INIT, S_RUN};
  - the 5-bit reg-index typedef.
- One sub-module, rf_wr_arb, contains the starvation counter and the grant logic.
  - Inputs: clk, reset, en(state==S_RUN), req0_valid, req1_valid.
  - Outputs: gnt0, gnt1.
- The top level holds the FSM, idx counter and output registers.

Test Plan:
- Reset 3 cycles, no requests -> after E1..E31 rf_RegWrite=1 and rf_Write_register=1..31. Data is 0 except reg 29 = 32'h0000fffc. init_done rises after E31. Readies stay 0 throughout.
- Post-init, req0 {addr=8, data=32'hdeadbeef} held 1 cycle -> req0_ready=1. Next cycle rf_* = {1, 8, deadbeef}. Following cycle rf_* = {0, 0, 0}.
- req0_valid held continuously plus req1 {26, 32'h00400010} -> req1 stalls exactly STARVE_LIMIT=4 cycles, is granted on the 5th, last_grant=1, and req0 resumes the next cycle.
- req0 {addr=0, data=32'h12345678} -> accepted, but rf_RegWrite=0 and rf_Write_register=0 on the following cycle.
- Reset asserted at init idx=15 -> all outputs return to 0 and init_done=0. The walk restarts at register 1, completes 31 writes, and $29 is written with SP_INIT.
- Reset asserted while req1 is stalled with starve_cnt=3 -> starve_cnt=0 after reset. Post-init arbitration again requires 4 stalled cycles before req1 is granted.
